// File: rtl/reset_sequencer_if.sv
// Status/control bundle between the reset sequencer and the domains it controls.
// The master side is the sequencer. The slave side is the software/domain side.
interface reset_sequencer_if #(
    parameter int NUM_DOM = 4
);
    localparam int ERR_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    logic               sw_rst_req;
    logic [NUM_DOM-1:0] dom_ready;
    logic [NUM_DOM-1:0] dom_rst;
    logic               seq_busy;
    logic               seq_done;
    logic               seq_err;
    logic [ERR_W-1:0]   err_dom;

    modport master (
        input  sw_rst_req,
        input  dom_ready,
        output dom_rst,
        output seq_busy,
        output seq_done,
        output seq_err,
        output err_dom
    );

    modport slave (
        output sw_rst_req,
        output dom_ready,
        input  dom_rst,
        input  seq_busy,
        input  seq_done,
        input  seq_err,
        input  err_dom
    );
endinterface

// File: rtl/reset_sequencer.sv
// Releases NUM_DOM reset domains in ascending order. Each release waits for the previous
// domain's ready, and a ready timeout re-asserts the stuck domain and latches an error.
module reset_sequencer #(
    parameter int NUM_DOM     = 4,
    parameter int HOLD_CYC    = 8,
    parameter int STEP_CYC    = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    reset_sequencer_if.master bus
);
    localparam int IW    = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam int MAX_A = (HOLD_CYC > STEP_CYC) ? HOLD_CYC : STEP_CYC;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
    localparam int CW    = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        S_HOLD     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_STEP     = 3'd2,
        S_DONE     = 3'd3,
        S_ERR      = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IW-1:0]      idx_r;
    logic [IW-1:0]      idx_s;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_s;
    logic [NUM_DOM-1:0] dom_rst_r;
    logic [NUM_DOM-1:0] dom_rst_s;
    logic               busy_r;
    logic               busy_s;
    logic               done_r;
    logic               done_s;
    logic               err_r;
    logic               err_s;
    logic [IW-1:0]      err_dom_r;
    logic [IW-1:0]      err_dom_s;

    // State register; outputs are registered alongside the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_HOLD;
            idx_r     <= {IW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            dom_rst_r <= {NUM_DOM{1'b1}};
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            err_dom_r <= {IW{1'b0}};
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            cnt_r     <= cnt_s;
            dom_rst_r <= dom_rst_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            err_r     <= err_s;
            err_dom_r <= err_dom_s;
        end
    end

    // Next-state logic: a software restart pre-empts every state.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        if (bus.sw_rst_req) begin
            state_s = S_HOLD;
            idx_s   = {IW{1'b0}};
            cnt_s   = {CW{1'b0}};
        end else begin
            case (state_r)
                S_HOLD: begin
                    if (cnt_r == CW'(HOLD_CYC - 1)) begin
                        state_s = S_WAIT_RDY;
                        idx_s   = {IW{1'b0}};
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end
                S_WAIT_RDY: begin
                    if (bus.dom_ready[idx_r]) begin
                        cnt_s = {CW{1'b0}};
                        if (idx_r == IW'(NUM_DOM - 1)) begin
                            state_s = S_DONE;
                        end else begin
                            state_s = S_STEP;
                        end
                    end else if (cnt_r == CW'(TIMEOUT_CYC - 1)) begin
                        state_s = S_ERR;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end
                S_STEP: begin
                    if (cnt_r == CW'(STEP_CYC - 1)) begin
                        state_s = S_WAIT_RDY;
                        idx_s   = idx_r + IW'(1);
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end
                S_DONE, S_ERR: begin
                    cnt_s = {CW{1'b0}};
                end
                default: begin
                    state_s = S_HOLD;
                    idx_s   = {IW{1'b0}};
                    cnt_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs line up with it.
    always_comb begin
        dom_rst_s = {NUM_DOM{1'b1}};
        busy_s    = 1'b1;
        done_s    = 1'b0;
        err_s     = 1'b0;
        err_dom_s = {IW{1'b0}};
        case (state_s)
            S_HOLD: begin
                dom_rst_s = {NUM_DOM{1'b1}};
            end
            S_WAIT_RDY, S_STEP: begin
                for (int j = 0; j < NUM_DOM; j++) begin
                    dom_rst_s[j] = (j > int'(idx_s));
                end
            end
            S_DONE: begin
                dom_rst_s = {NUM_DOM{1'b0}};
                busy_s    = 1'b0;
                done_s    = 1'b1;
            end
            S_ERR: begin
                // The stuck domain goes back into reset; earlier domains stay released.
                for (int j = 0; j < NUM_DOM; j++) begin
                    dom_rst_s[j] = (j >= int'(idx_s));
                end
                busy_s    = 1'b0;
                err_s     = 1'b1;
                err_dom_s = idx_s;
            end
            default: begin
                dom_rst_s = {NUM_DOM{1'b1}};
            end
        endcase
    end

    assign bus.dom_rst  = dom_rst_r;
    assign bus.seq_busy = busy_r;
    assign bus.seq_done = done_r;
    assign bus.seq_err  = err_r;
    assign bus.err_dom  = err_dom_r;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer. Stimulus queues expected outputs per edge,
// and a negedge monitor pops and compares them.
module tb_reset_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   edge_cnt = 0;
    int   vectors  = 0;
    int   errors   = 0;

    reset_sequencer_if #(.NUM_DOM(4)) bus ();

    reset_sequencer #(
        .NUM_DOM(4), .HOLD_CYC(8), .STEP_CYC(4), .TIMEOUT_CYC(64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct packed {
        int         at;
        logic [3:0] rst_v;
        logic       busy;
        logic       done;
        logic       err;
        logic [1:0] edom;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    task automatic expect_at(input int at, input logic [3:0] r, input logic b, input logic d,
                             input logic e, input logic [1:0] ed, input string nm);
        exp_t x;
        x.at = at; x.rst_v = r; x.busy = b; x.done = d; x.err = e; x.edom = ed;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic wait_until(input int at);
        while (edge_cnt < at) @(negedge clk);
    endtask

    // Hold rst for a few edges, checking the reset values, and return the edge-0 base.
    task automatic do_reset(output int b, input logic sw_v);
        @(negedge clk);
        rst = 1'b1;
        bus.sw_rst_req = sw_v;
        expect_at(edge_cnt + 2, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, "reset_values");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.sw_rst_req = 1'b0;
        b = edge_cnt;
    endtask

    // Monitor: compares every queued expectation at the edge it names.
    always @(negedge clk) begin
        exp_t  x;
        string nm;
        while (exp_q.size() > 0 && exp_q[0].at <= edge_cnt) begin
            x  = exp_q.pop_front();
            nm = name_q.pop_front();
            vectors++;
            if (x.at != edge_cnt || bus.dom_rst !== x.rst_v || bus.seq_busy !== x.busy ||
                bus.seq_done !== x.done || bus.seq_err !== x.err || bus.err_dom !== x.edom) begin
                errors++;
                $display("FAIL %s @edge %0d: got dom_rst=%b busy=%b done=%b err=%b err_dom=%0d, want dom_rst=%b busy=%b done=%b err=%b err_dom=%0d (edge %0d)",
                         nm, edge_cnt, bus.dom_rst, bus.seq_busy, bus.seq_done, bus.seq_err,
                         bus.err_dom, x.rst_v, x.busy, x.done, x.err, x.edom, x.at);
            end
        end
    end

    initial begin
        int b;
        int s;
        int s2;
        rst = 1'b1;
        bus.sw_rst_req = 1'b0;
        bus.dom_ready  = 4'b1111;

        // All domains ready: nominal release timing.
        do_reset(b, 1'b0);
        expect_at(b + 7,  4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, "nom_hold_e7");
        expect_at(b + 8,  4'b1110, 1'b1, 1'b0, 1'b0, 2'd0, "nom_rel0_e8");
        expect_at(b + 12, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0, "nom_step_e12");
        expect_at(b + 13, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0, "nom_rel1_e13");
        expect_at(b + 18, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0, "nom_rel2_e18");
        expect_at(b + 23, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, "nom_rel3_e23");
        expect_at(b + 24, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, "nom_done_e24");
        wait_until(b + 26);

        // Restart from DONE; dom_ready[0] glitches while idx=2 is waiting.
        s = edge_cnt + 1;
        expect_at(s,      4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, "sw_done_s");
        expect_at(s + 7,  4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, "sw_done_s7");
        expect_at(s + 8,  4'b1110, 1'b1, 1'b0, 1'b0, 2'd0, "sw_done_s8");
        expect_at(s + 13, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0, "sw_done_s13");
        expect_at(s + 19, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0, "glitch_s19");
        expect_at(s + 21, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0, "glitch_s21");
        expect_at(s + 23, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, "glitch_s23");
        expect_at(s + 24, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, "glitch_done");
        bus.sw_rst_req = 1'b1;
        @(negedge clk);
        bus.sw_rst_req = 1'b0;
        wait_until(s + 17);
        bus.dom_ready[0] = 1'b0;
        wait_until(s + 20);
        bus.dom_ready[0] = 1'b1;
        wait_until(s + 26);

        // Domain 1 never ready: timeout at edge 77.
        bus.dom_ready = 4'b1101;
        do_reset(b, 1'b0);
        expect_at(b + 13, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0, "to_rel1_e13");
        expect_at(b + 76, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0, "to_wait_e76");
        expect_at(b + 77, 4'b1110, 1'b0, 1'b0, 1'b1, 2'd1, "to_err_e77");
        expect_at(b + 80, 4'b1110, 1'b0, 1'b0, 1'b1, 2'd1, "to_err_hold");
        wait_until(b + 81);
        bus.dom_ready = 4'b1111;
        wait_until(b + 83);

        // Restart from ERR, then restart again during STEP of idx=1.
        s  = edge_cnt + 1;
        s2 = s + 16;
        expect_at(s,       4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, "sw_err_s");
        expect_at(s + 8,   4'b1110, 1'b1, 1'b0, 1'b0, 2'd0, "sw_err_s8");
        expect_at(s + 15,  4'b1100, 1'b1, 1'b0, 1'b0, 2'd0, "step1_s15");
        expect_at(s2,      4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, "sw_step_s2");
        expect_at(s2 + 7,  4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, "sw_step_s2_7");
        expect_at(s2 + 8,  4'b1110, 1'b1, 1'b0, 1'b0, 2'd0, "sw_step_s2_8");
        expect_at(s2 + 24, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, "sw_step_done");
        bus.sw_rst_req = 1'b1;
        @(negedge clk);
        bus.sw_rst_req = 1'b0;
        wait_until(s2 - 1);
        bus.sw_rst_req = 1'b1;
        @(negedge clk);
        bus.sw_rst_req = 1'b0;
        wait_until(s2 + 26);

        // rst together with sw_rst_req, then rst again mid-sequence at edge 15.
        do_reset(b, 1'b1);
        expect_at(b + 8,  4'b1110, 1'b1, 1'b0, 1'b0, 2'd0, "mid_rel0_e8");
        expect_at(b + 14, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0, "mid_step_e14");
        expect_at(b + 15, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, "mid_rst_e15");
        wait_until(b + 14);
        rst = 1'b1;
        wait_until(b + 16);
        rst = 1'b0;
        s = edge_cnt;
        expect_at(s + 7,  4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, "mid_re_e7");
        expect_at(s + 8,  4'b1110, 1'b1, 1'b0, 1'b0, 2'd0, "mid_re_e8");
        expect_at(s + 24, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, "mid_re_done");
        wait_until(s + 26);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL provide parameter NUM_DOM, default 4, the number of reset domains released in index order 0..NUM_DOM-1.
REQ-002 The block SHALL provide parameter HOLD_CYC, default 8, the number of cycles all domains are held in reset before release starts (legal range >=1).
REQ-003 The block SHALL provide parameter STEP_CYC, default 4, the gap in cycles between a domain reporting ready and release of the next domain (legal range >=1).
REQ-004 The block SHALL provide parameter TIMEOUT_CYC, default 64, the maximum number of cycles to wait for a domain's ready (legal range >=1).
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 sw_rst_req  input  1  software restart request, sampled each edge.
REQ-008 dom_ready  input  NUM_DOM  per-domain "out of reset and ready" status, synchronous to clk.
REQ-009 dom_rst  output  NUM_DOM  per-domain reset, active-high, registered.
REQ-010 seq_busy  output  1  sequence in progress.
REQ-011 seq_done  output  1  all domains released and ready.
REQ-012 seq_err  output  1  ready timeout occurred.
REQ-013 err_dom  output  clog2(NUM_DOM), minimum 1 bit  index of the domain that timed out.

Function
REQ-014 The FSM SHALL have the states HOLD, WAIT_RDY, STEP, DONE and ERR, with a domain index idx and a single cycle counter.
REQ-015 HOLD SHALL keep all dom_rst bits at 1; after HOLD_CYC edges in HOLD, dom_rst[0] SHALL be 0 and the FSM SHALL enter WAIT_RDY with idx=0.
REQ-016 WAIT_RDY: the edge that samples dom_ready[idx]=1 SHALL move the FSM to STEP, or to DONE if idx=NUM_DOM-1.
REQ-017 WAIT_RDY timeout: if dom_ready[idx] is sampled 0 on TIMEOUT_CYC consecutive edges, the last of those edges SHALL move the FSM to ERR.
REQ-018 STEP: STEP_CYC edges after entry, dom_rst[idx+1] SHALL be 0, idx SHALL increment and the FSM SHALL return to WAIT_RDY.
REQ-019 dom_ready[j] SHALL be ignored except for j=idx while in WAIT_RDY; deassertion on an already-released domain SHALL have no effect.
REQ-020 DONE SHALL hold seq_busy=0 and seq_done=1, with all dom_rst bits at 0, until a restart.
REQ-021 ERR SHALL set seq_err=1, seq_busy=0 and err_dom=idx, and SHALL set dom_rst[idx] back to 1.
REQ-022 In ERR, domains below idx SHALL stay released and domains above idx SHALL stay asserted; ERR SHALL hold until a restart.
REQ-023 sw_rst_req=1 sampled in any state SHALL, at that edge, set all dom_rst bits to 1, seq_busy=1, seq_done=0, seq_err=0, err_dom=0 and idx=0, and enter HOLD with the counter cleared.
REQ-024 After a restart, dom_rst[0] SHALL fall HOLD_CYC edges after the sampling edge.
REQ-025 sw_rst_req held high SHALL keep the FSM in HOLD, with the counter cleared each edge.
REQ-026 seq_busy SHALL be 1 in HOLD, WAIT_RDY and STEP, and 0 otherwise.
REQ-027 dom_rst SHALL never be asserted and deasserted in the same cycle, and SHALL only be released in ascending index order.

Reset
REQ-028 While rst=1: state=HOLD, dom_rst=all 1, seq_busy=1, seq_done=0, seq_err=0, err_dom=0, idx=0, counter=0.
REQ-029 rst SHALL take priority over sw_rst_req and over all FSM activity, including mid-sequence.
REQ-030 Edge 1 SHALL be the first edge that samples rst=0; the HOLD count SHALL start there.

Verification (defaults; edge numbering per REQ-030)
REQ-031 Scenario: dom_ready tied 4'b1111 -> dom_rst[0] falls at edge 8, dom_rst[1] at edge 13, dom_rst[2] at edge 18, dom_rst[3] at edge 23; seq_done=1 and seq_busy=0 after edge 24.
REQ-032 Scenario: dom_ready[1] stuck 0, others 1 -> dom_rst[1] falls at edge 13; at edge 77 seq_err=1, err_dom=1, dom_rst=4'b1110, seq_busy=0.
REQ-033 Scenario: sw_rst_req pulsed in DONE at edge s -> dom_rst=4'b1111 and seq_done=0 after s; dom_rst[0] falls at s+8; the full sequence repeats with the same spacing.
REQ-034 Scenario: sw_rst_req pulsed during STEP of idx=1, and separately in ERR -> immediate return to HOLD, all dom_rst=1, seq_err cleared, sequence restarts from idx 0.
REQ-035 Scenario: rst and sw_rst_req both high, then rst asserted at edge 15 mid-sequence -> reset values per REQ-028 and restart timing per REQ-030.
REQ-036 Scenario: dom_ready[0] dropped to 0 for 3 cycles during WAIT_RDY of idx=2 -> no effect; sequence completes as in REQ-031.
